// File: rtl/conv_relu_pool.sv
// Post-convolution stage: bias + ReLU + shift requantisation to OUT_W bits, then a
// 2x2/stride-2 max-pool over a raster-ordered FMAP_W x FMAP_H map using a half-width line buffer.
module conv_relu_pool #(
    parameter int IN_W   = 20,
    parameter int OUT_W  = 8,
    parameter int FMAP_W = 24,
    parameter int FMAP_H = 24,
    parameter int SHIFT  = 8
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clear_i,
    input  logic                    valid_i,
    input  logic signed [IN_W-1:0]  data_i,
    input  logic signed [IN_W-1:0]  bias_i,
    output logic                    valid_o,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    done_o
);

    localparam int COL_W = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
    localparam int ROW_W = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
    localparam int LB_N  = FMAP_W / 2;
    localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

    localparam logic [OUT_W-1:0]       Q_MAX     = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0]   Q_MAX_EXT = (IN_W+1)'(2**(OUT_W-1) - 1);
    localparam logic [COL_W-1:0]       COL_LAST  = COL_W'(FMAP_W - 1);
    localparam logic [ROW_W-1:0]       ROW_LAST  = ROW_W'(FMAP_H - 1);

    // Quantise stage
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shifted;
    logic                 q_valid_d, q_valid_q;
    logic [OUT_W-1:0]     q_val_d, q_val_q;

    always_comb begin
        // One extra bit keeps the bias addition exact for any operand pair.
        sum       = {data_i[IN_W-1], data_i} + {bias_i[IN_W-1], bias_i};
        shifted   = sum >>> SHIFT;
        q_valid_d = 1'b0;
        q_val_d   = q_val_q;
        if (!clear_i && valid_i) begin
            q_valid_d = 1'b1;
            if (sum[IN_W] || (sum == '0)) begin
                q_val_d = '0;
            end else if (shifted > Q_MAX_EXT) begin
                q_val_d = Q_MAX;
            end else begin
                q_val_d = shifted[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            q_valid_q <= 1'b0;
            q_val_q   <= '0;
        end else begin
            q_valid_q <= q_valid_d;
            q_val_q   <= q_val_d;
        end
    end

    // Pool stage
    logic [COL_W-1:0] col_d, col_q;
    logic [ROW_W-1:0] row_d, row_q;
    logic [OUT_W-1:0] hold_d, hold_q;
    logic             valid_o_d, valid_o_q;
    logic             done_o_d, done_o_q;
    logic [OUT_W-1:0] data_o_d, data_o_q;
    logic [OUT_W-1:0] h_max;
    logic [OUT_W-1:0] lb_rd;
    logic [LB_AW-1:0] lb_idx;
    logic             lb_we;
    logic [OUT_W-1:0] lb_mem [LB_N];

    assign lb_idx = LB_AW'(col_q >> 1);
    assign lb_rd  = lb_mem[lb_idx];
    // Values are non-negative after ReLU, so unsigned compares are exact.
    assign h_max  = (hold_q > q_val_q) ? hold_q : q_val_q;

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        hold_d    = hold_q;
        valid_o_d = 1'b0;
        done_o_d  = 1'b0;
        data_o_d  = data_o_q;
        lb_we     = 1'b0;
        if (clear_i) begin
            col_d  = '0;
            row_d  = '0;
            hold_d = '0;
        end else if (q_valid_q) begin
            if (!col_q[0]) begin
                hold_d = q_val_q;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                valid_o_d = 1'b1;
                data_o_d  = (lb_rd > h_max) ? lb_rd : h_max;
                done_o_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end
            // Wrap at the end of the map so the next map can follow with no clear.
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col_q     <= '0;
            row_q     <= '0;
            hold_q    <= '0;
            valid_o_q <= 1'b0;
            done_o_q  <= 1'b0;
            data_o_q  <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            hold_q    <= hold_d;
            valid_o_q <= valid_o_d;
            done_o_q  <= done_o_d;
            data_o_q  <= data_o_d;
        end
    end

    // Every entry is rewritten on an even row before an odd row reads it, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (lb_we) begin
            lb_mem[lb_idx] <= h_max;
        end
    end

    assign valid_o = valid_o_q;
    assign done_o  = done_o_q;
    assign data_o  = data_o_q;

endmodule

// File: tb/tb_conv_relu_pool.sv
// Randomised scoreboard bench for conv_relu_pool: a map-level reference model predicts every
// pooled pixel, its done flag and its arrival cycle; a monitor compares what the DUT emits.
`timescale 1ns/1ps
module tb_conv_relu_pool;

    localparam int IN_W  = 20;
    localparam int OUT_W = 8;
    localparam int FW    = 24;
    localparam int FH    = 24;
    localparam int SHIFT = 8;
    localparam int NPIX  = FW * FH;
    localparam int QMAX  = 2**(OUT_W-1) - 1;

    logic                    clk_i   = 1'b0;
    logic                    rstn_i  = 1'b0;
    logic                    clear_i = 1'b0;
    logic                    valid_i = 1'b0;
    logic signed [IN_W-1:0]  data_i  = '0;
    logic signed [IN_W-1:0]  bias_i  = '0;
    logic                    valid_o;
    logic signed [OUT_W-1:0] data_o;
    logic                    done_o;

    conv_relu_pool #(
        .IN_W(IN_W), .OUT_W(OUT_W), .FMAP_W(FW), .FMAP_H(FH), .SHIFT(SHIFT)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .clear_i(clear_i), .valid_i(valid_i),
        .data_i(data_i), .bias_i(bias_i),
        .valid_o(valid_o), .data_o(data_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    longint cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int     val;
        bit     done;
        longint cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     stream[$];
    int     img[NPIX];
    bit     pend_v   = 1'b0;
    int     pend_q   = 0;
    longint pend_cyc = 0;
    int     n_chk    = 0;
    int     n_fail   = 0;
    int     n_out    = 0;
    bit     end_chk  = 1'b0;
    bit     end_done = 1'b0;
    logic signed [OUT_W-1:0] last_data = '0;

    // ReLU then divide by 2^SHIFT, saturating at the largest positive output.
    function automatic int quant(int d, int b);
        longint s;
        s = longint'(d) + longint'(b);
        if (s <= 0) return 0;
        s = s / (longint'(1) << SHIFT);
        return (s > QMAX) ? QMAX : int'(s);
    endfunction

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // Accepted samples since the last clear form a stream of back-to-back maps; each completed
    // 2x2 window yields one expected output, arriving two cycles after its last sample.
    function automatic void commit(int qv, longint c);
        int p, m, r, k, mx;
        exp_t e;
        stream.push_back(qv);
        p = stream.size() - 1;
        m = (p / NPIX) * NPIX;
        r = (p - m) / FW;
        k = (p - m) % FW;
        if ((r % 2 == 1) && (k % 2 == 1)) begin
            mx = max2(max2(stream[m + (r-1)*FW + k-1], stream[m + (r-1)*FW + k]),
                      max2(stream[m + r*FW + k-1],     stream[m + r*FW + k]));
            e.val  = mx;
            e.done = (r == FH-1) && (k == FW-1);
            e.cyc  = c + 2;
            exp_q.push_back(e);
        end
    endfunction

    // A sample becomes real only if the following cycle does not clear it out of the Q stage.
    task automatic cycle(bit v, int d, bit clr, int b);
        @(posedge clk_i);
        #1;
        valid_i = v;
        data_i  = IN_W'(d);
        clear_i = clr;
        bias_i  = IN_W'(b);
        if (clr) begin
            pend_v = 1'b0;
            stream.delete();
        end else begin
            if (pend_v) commit(pend_q, pend_cyc);
            pend_v   = v;
            pend_q   = quant(d, b);
            pend_cyc = cyc;
        end
    endtask

    function automatic int rnd_d();
        return int'($urandom_range(80000)) - 40000;
    endfunction

    function automatic int rnd_b();
        return int'($urandom_range(20000)) - 10000;
    endfunction

    task automatic drive_map(int b, int gap_pct, bit clr_first, int npix);
        for (int i = 0; i < npix; i++) begin
            while (int'($urandom_range(99)) < gap_pct) cycle(1'b0, rnd_d(), 1'b0, b);
            cycle(1'b1, img[i], clr_first && (i == 0), b);
        end
    endtask

    task automatic fill_const(int d);
        for (int i = 0; i < NPIX; i++) img[i] = d;
    endtask

    task automatic fill_ramp_up();
        for (int i = 0; i < NPIX; i++) img[i] = ((i / FW) + (i % FW)) << 8;
    endtask

    task automatic fill_ramp_down();
        for (int i = 0; i < NPIX; i++) img[i] = (FH - 1 - (i / FW)) << 8;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NPIX; i++) img[i] = rnd_d();
    endtask

    // Monitor: checks reset state, pooled outputs in order, done/latency, and data_o holding.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            last_data = '0;
            n_chk++;
            if (valid_o !== 1'b0 || data_o !== '0 || done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state valid_o=%b data_o=%0d done_o=%b, required 0/0/0",
                         valid_o, data_o, done_o);
            end
        end else begin
            n_chk++;
            if (done_o === 1'b1 && valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL done_without_valid done_o=%b valid_o=%b", done_o, valid_o);
            end
            if (valid_o === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output data_o=%0d done_o=%b at cycle %0d, none expected",
                             data_o, done_o, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (int'(data_o) != e.val || done_o !== e.done || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL pooled_out #%0d data_o=%0d done_o=%b cycle=%0d, required data=%0d done=%b cycle=%0d",
                                 n_out, data_o, done_o, cyc, e.val, e.done, e.cyc);
                    end
                end
                n_out++;
                last_data = data_o;
            end else if (data_o !== last_data) begin
                n_fail++;
                $display("FAIL data_hold data_o=%0d while idle, required %0d", data_o, last_data);
            end
            if (end_chk && !end_done) begin
                end_done = 1'b1;
                n_chk++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL missing_outputs %0d expected outputs never appeared, required 0",
                             exp_q.size());
                end
            end
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cd[4];
        int cb[4];
        int rb;
        cd = '{1000, -500, 524287, 255};
        cb = '{24, 100, 524287, 0};

        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;

        // Quantisation corners: uniform maps, every window equal to quant(d, b).
        for (int k = 0; k < 4; k++) begin
            fill_const(cd[k]);
            drive_map(cb[k], 0, 1'b0, NPIX);
        end

        // Diagonal ramp, dense and with 50% gaps.
        fill_ramp_up();
        drive_map(0, 0, 1'b0, NPIX);
        fill_ramp_up();
        drive_map(0, 50, 1'b0, NPIX);

        // Asynchronous reset in the middle of a map, then a clean full map.
        fill_rand();
        rb = rnd_b();
        drive_map(rb, 30, 1'b0, 100);
        @(posedge clk_i);
        #1;
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        clear_i = 1'b0;
        pend_v  = 1'b0;
        stream.delete();
        exp_q.delete();
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        fill_rand();
        drive_map(rnd_b(), 20, 1'b0, NPIX);

        // Partial map abandoned by clear, then a descending map.
        fill_rand();
        drive_map(rnd_b(), 0, 1'b0, 30);
        cycle(1'b0, 0, 1'b1, 0);
        fill_ramp_down();
        drive_map(0, 0, 1'b0, NPIX);

        // Back-to-back maps, then a map whose first sample collides with clear.
        fill_ramp_up();
        drive_map(0, 0, 1'b0, NPIX);
        fill_rand();
        drive_map(rnd_b(), 0, 1'b0, NPIX);
        fill_ramp_down();
        drive_map(0, 0, 1'b1, NPIX);
        cycle(1'b1, 5 << 8, 1'b0, 0);

        repeat (10) cycle(1'b0, 0, 1'b0, 0);
        end_chk = 1'b1;
        repeat (3) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
